// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : age-ordered two-source write-back arbiter for the RF write port
// Revision   : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter #(
  parameter int DEPTH   = 2,
  parameter int STAMP_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [4:0]  s0_wa,
  input  logic [31:0] s0_wn,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [4:0]  s1_wa,
  input  logic [31:0] s1_wn,
  input  logic        flush,
  output logic [4:0]  wa,
  output logic [31:0] wn,
  output logic        we,
  output logic [31:0] busy,
  output logic        idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [STAMP_W-1:0] HALF = {1'b1, {(STAMP_W-1){1'b0}}};

  logic [1:0]              in_valid;
  logic [1:0][4:0]         in_wa;
  logic [1:0][31:0]        in_wn;
  logic [1:0]              src_ready;
  logic [1:0]              enq;
  logic [1:0]              pop;
  logic [1:0]              head_vld;
  logic [1:0][4:0]         head_wa;
  logic [1:0][31:0]        head_wn;
  logic [1:0][STAMP_W-1:0] head_st;
  logic [1:0][31:0]        qbusy;

  logic [STAMP_W-1:0] stamp_q;
  logic [4:0]         wa_q;
  logic [31:0]        wn_q;
  logic               we_q;

  assign in_valid = {s1_valid, s0_valid};
  assign in_wa    = {s1_wa, s0_wa};
  assign in_wn    = {s1_wn, s0_wn};
  assign enq      = in_valid & src_ready & {2{~flush}};

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [DEPTH-1:0]   vld_q;
    logic [AW-1:0]      wr_q;
    logic [AW-1:0]      rd_q;
    logic [4:0]         ewa_q [DEPTH];
    logic [31:0]        ewn_q [DEPTH];
    logic [STAMP_W-1:0] est_q [DEPTH];
    logic [31:0]        match;

    // Per-slot valid bits make full/empty and the busy scan direct lookups.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
      end else if (flush) begin
        vld_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
      end else begin
        if (pop[s]) begin
          vld_q[rd_q] <= 1'b0;
          rd_q        <= rd_q + AW'(1);
        end
        if (enq[s]) begin
          vld_q[wr_q] <= 1'b1;
          wr_q        <= wr_q + AW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (enq[s]) begin
        ewa_q[wr_q] <= in_wa[s];
        ewn_q[wr_q] <= in_wn[s];
        est_q[wr_q] <= stamp_q;
      end
    end

    always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i]) match[ewa_q[i]] = 1'b1;
      end
    end

    assign src_ready[s] = rst_n & ~vld_q[wr_q];
    assign head_vld[s]  = vld_q[rd_q];
    assign head_wa[s]   = ewa_q[rd_q];
    assign head_wn[s]   = ewn_q[rd_q];
    assign head_st[s]   = est_q[rd_q];
    assign qbusy[s]     = match;
  end

  logic [STAMP_W-1:0] st_diff;
  logic               s0_older;
  logic               gnt0;
  logic               gnt1;

  // Equal stamps fall through to source 1: the load is the older instruction.
  assign st_diff  = head_st[1] - head_st[0];
  assign s0_older = (st_diff != '0) && (st_diff < HALF);
  assign gnt0     = head_vld[0] & (~head_vld[1] | s0_older);
  assign gnt1     = head_vld[1] & ~gnt0;
  assign pop      = flush ? 2'b00 : {gnt1, gnt0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_q <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wn_q    <= '0;
    end else begin
      if (|enq) stamp_q <= stamp_q + STAMP_W'(1);
      if (|pop) begin
        we_q <= (head_wa[gnt1] != 5'd0);
        wa_q <= head_wa[gnt1];
        wn_q <= head_wn[gnt1];
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign s0_ready = src_ready[0];
  assign s1_ready = src_ready[1];
  assign we       = we_q;
  assign wa       = wa_q;
  assign wn       = wn_q;
  assign busy     = (qbusy[0] | qbusy[1] | (we_q ? (32'd1 << wa_q) : 32'd0)) & ~32'd1;
  assign idle     = ~head_vld[0] & ~head_vld[1] & ~we_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// tb_wb_arbiter : directed-vector bench for wb_arbiter
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_wa, s1_wa;
  logic [31:0] s0_wn, s1_wn;
  logic        flush;
  logic [4:0]  wa;
  logic [31:0] wn;
  logic        we;
  logic [31:0] busy;
  logic        idle;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] log_q [$];
  logic [36:0] exp_q [$];

  wb_arbiter #(.DEPTH(2), .STAMP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_wa(s0_wa), .s0_wn(s0_wn),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_wa(s1_wa), .s1_wn(s1_wn),
    .flush(flush), .wa(wa), .wn(wn), .we(we), .busy(busy), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (we) log_q.push_back({wa, wn});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_n"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n0, n1, rdy_low;
    logic a0, a1;
    rst_n = 1'b0; flush = 1'b0;
    s0_valid = 1'b0; s0_wa = '0; s0_wn = '0;
    s1_valid = 1'b0; s1_wa = '0; s1_wn = '0;

    // Reset values
    repeat (2) tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wa", 64'(wa), 64'd0);
    chk("rst_wn", 64'(wn), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_rdy", 64'({s1_ready, s0_ready}), 64'd0);

    // Single write x5 = 0x1234
    @(negedge clk);
    rst_n = 1'b1;
    s0_valid = 1'b1; s0_wa = 5'd5; s0_wn = 32'h1234;
    tick();
    s0_valid = 1'b0;
    chk("w1_busy_e1", 64'(busy), 64'h20);
    chk("w1_we_e1", 64'(we), 64'd0);
    tick();
    chk("w1_we_e2", 64'(we), 64'd1);
    chk("w1_wa_e2", 64'(wa), 64'd5);
    chk("w1_wn_e2", 64'(wn), 64'h1234);
    chk("w1_busy_e2", 64'(busy), 64'h20);
    tick();
    chk("w1_busy_e3", 64'(busy), 64'd0);
    chk("w1_idle_e3", 64'(idle), 64'd1);
    log_q.delete();

    // Same-cycle tie on x3: source 1 first
    s0_valid = 1'b1; s0_wa = 5'd3; s0_wn = 32'hA;
    s1_valid = 1'b1; s1_wa = 5'd3; s1_wn = 32'hB;
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    chk("tie_busy0", 64'(busy), 64'h8);
    tick();
    chk("tie_wn0", 64'(wn), 64'hB);
    chk("tie_busy1", 64'(busy), 64'h8);
    tick();
    chk("tie_wn1", 64'(wn), 64'hA);
    chk("tie_busy2", 64'(busy), 64'h8);
    tick();
    chk("tie_busy3", 64'(busy), 64'd0);
    exp_q.push_back({5'd3, 32'hB});
    exp_q.push_back({5'd3, 32'hA});
    chk_log("tie");

    // Advance stamp 2 -> 14 with x0 writes (never committed)
    for (int i = 0; i < 12; i++) begin
      s0_valid = 1'b1; s0_wa = 5'd0; s0_wn = 32'(i);
      tick();
      chk("x0pre_busy", 64'(busy), 64'd0);
    end
    s0_valid = 1'b0;
    repeat (2) tick();
    chk("x0pre_idle", 64'(idle), 64'd1);
    chk("x0pre_log", 64'(log_q.size()), 64'd0);

    // Wrap: stamps 14 (tie), 15 (s0 x1), 0 (s1 x2)
    s0_valid = 1'b1; s0_wa = 5'd4; s0_wn = 32'h44;
    s1_valid = 1'b1; s1_wa = 5'd6; s1_wn = 32'h66;
    tick();
    s0_wa = 5'd1; s0_wn = 32'h11; s1_valid = 1'b0;
    tick();
    s0_valid = 1'b0; s1_valid = 1'b1; s1_wa = 5'd2; s1_wn = 32'h22;
    tick();
    s1_valid = 1'b0;
    chk("wrap_busy", 64'(busy), 64'h16);
    repeat (4) tick();
    exp_q.push_back({5'd6, 32'h66});
    exp_q.push_back({5'd4, 32'h44});
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd2, 32'h22});
    chk_log("wrap");

    // x0 drop followed by x9
    s1_valid = 1'b1; s1_wa = 5'd0; s1_wn = 32'hFFFF;
    tick();
    chk("x0_busy1", 64'(busy), 64'd0);
    s1_wa = 5'd9; s1_wn = 32'h99;
    tick();
    s1_valid = 1'b0;
    chk("x0_we", 64'(we), 64'd0);
    chk("x0_busy2", 64'(busy), 64'h200);
    tick();
    chk("x9_we", 64'(we), 64'd1);
    chk("x9_wa", 64'(wa), 64'd9);
    chk("x9_wn", 64'(wn), 64'h99);
    tick();
    exp_q.push_back({5'd9, 32'h99});
    chk_log("x0");

    // Backpressure: both sources offer every cycle for 10 cycles
    n0 = 0; n1 = 0; rdy_low = 0;
    for (int i = 0; i < 10; i++) begin
      s0_valid = 1'b1; s0_wa = 5'(1 + n0 % 15);  s0_wn = 32'h1000 + 32'(n0);
      s1_valid = 1'b1; s1_wa = 5'(16 + n1 % 15); s1_wn = 32'h2000 + 32'(n1);
      a0 = s0_ready; a1 = s1_ready;
      if (!a0 || !a1) rdy_low++;
      if (a1) exp_q.push_back({s1_wa, s1_wn});
      if (a0) exp_q.push_back({s0_wa, s0_wn});
      tick();
      if (a0) n0++;
      if (a1) n1++;
      if (i >= 1) chk($sformatf("bp_we_%0d", i), 64'(we), 64'd1);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    chk("bp_rdylow", 64'(rdy_low > 0), 64'd1);
    repeat (8) tick();
    chk("bp_idle", 64'(idle), 64'd1);
    chk_log("bp");

    // Flush with three pending writes and a concurrent s0 offer
    s0_valid = 1'b1; s0_wa = 5'd10; s0_wn = 32'hA0;
    s1_valid = 1'b1; s1_wa = 5'd11; s1_wn = 32'hB0;
    tick();
    s0_valid = 1'b0; s1_wa = 5'd12; s1_wn = 32'hC0;
    tick();
    s1_valid = 1'b0;
    chk("fl_pre_busy", 64'(busy), 64'h1C00);
    flush = 1'b1; s0_valid = 1'b1; s0_wa = 5'd13; s0_wn = 32'hD0;
    tick();
    flush = 1'b0; s0_valid = 1'b0;
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_idle", 64'(idle), 64'd1);
    chk("fl_we", 64'(we), 64'd0);
    log_q.delete();
    tick();
    chk("fl_we2", 64'(we), 64'd0);
    chk("fl_log", 64'(log_q.size()), 64'd0);

    // Async reset mid-cycle with pending writes
    s0_valid = 1'b1; s0_wa = 5'd14; s0_wn = 32'hE0;
    s1_valid = 1'b1; s1_wa = 5'd15; s1_wn = 32'hF0;
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
    chk("ar_pre_we", 64'(we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we", 64'(we), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_rdy", 64'({s1_ready, s0_ready}), 64'd0);
    tick();
    chk("ar_rdy2", 64'({s1_ready, s0_ready}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rel_rdy", 64'({s1_ready, s0_ready}), 64'd3);
    chk("ar_rel_idle", 64'(idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
